chroni_vram_arbiter: RTL
========================

# chroni_vram_arbiter

Memory-side responder for the chroni video fetch port. It serves chroni's `rd_req`/`rd_ack` read handshake, honours `dma_req` by halting the CPU, and time-multiplexes a single synchronous VRAM/ROM port between video reads and CPU reads and writes. It sits between chroni, the CPU bus decoder and the 8 KiB VRAM.

## Interface
Parameters:
- `ADDR_W`, default 13: VRAM address width.
- `MEM_LATENCY`, default 2: cycles from `mem_addr` valid to `mem_rdata` valid; legal range 1–7.

Ports:
- `sys_clk`  in  1  system clock; reset `reset_n`, synchronous, active-low, clock `sys_clk`.
- `reset_n`  in  1  synchronous active-low reset.
- `vid_rd_req`  in  1  video read request, level, held until ack.
- `vid_addr`  in  ADDR_W  video read address.
- `vid_rd_ack`  out  1  one-cycle ack; `vid_data` valid in the same cycle.
- `vid_data`  out  8  video read data.
- `vid_dma_req`  in  1  video owns the bus for the current scanline.
- `cpu_req`  in  1  CPU access request, level, held until ack.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_wdata`  in  8  CPU write data.
- `cpu_rdata`  out  8  CPU read data, valid with `cpu_ack`.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_halt`  out  1  CPU must not start new cycles (RDY low).
- `mem_addr`  out  ADDR_W  VRAM address.
- `mem_wdata`  out  8  VRAM write data.
- `mem_we`  out  1  VRAM write strobe, one cycle.
- `mem_rdata`  in  8  VRAM read data.

## Operation
- States: IDLE, V_ADDR, V_WAIT, V_ACK, C_ADDR, C_WAIT, C_ACK.
- IDLE: if `vid_rd_req`, latch `vid_addr` and go to V_ADDR. Otherwise, if `cpu_req && !vid_dma_req`, latch the CPU address, data and `we`, then go to C_ADDR. Video always wins a tie.
- V_ADDR: drive `mem_addr`, load the latency counter with `MEM_LATENCY-1`, then go to V_WAIT. V_WAIT counts down to 0 and registers `mem_rdata` into `vid_data`, then goes to V_ACK.
- V_ACK: `vid_rd_ack`=1 only if `vid_rd_req` is still high. Otherwise the read is aborted silently, which covers chroni resetting on frame start or mode change. Go to IDLE.
- C_ADDR write: `mem_we`=1 for one cycle with `mem_addr`/`mem_wdata`, then go to C_ACK. C_ADDR read: same path as video via C_WAIT, capturing into `cpu_rdata`.
- C_ACK: `cpu_ack`=1 for one cycle, then go to IDLE.
- Addresses and data are latched at acceptance. Changes on the inputs mid-transaction are ignored.
- `cpu_halt` is the registered copy of `vid_dma_req`. A CPU transaction already accepted completes normally even if `vid_dma_req` rises during it; video waits for it to finish.
- No request is accepted in the ack cycle itself. Chroni deasserts `rd_req` the cycle after the ack, so that stale high level is never re-serviced.
- `vid_data` and `cpu_rdata` hold their value until the next capture.

## Timing
- Reset values: state IDLE; `vid_rd_ack`, `cpu_ack`, `mem_we`, `cpu_halt` = 0; `vid_data`, `cpu_rdata`, `mem_addr`, `mem_wdata` = 0.
- Video read, request sampled in cycle 0: `mem_addr` valid in cycle 1, data captured in cycle `MEM_LATENCY`+1, `vid_rd_ack` in cycle `MEM_LATENCY`+2. With the default this is an ack in cycle 4.
- Throughput is at most one access per `MEM_LATENCY`+3 cycles.
- CPU write: accepted in cycle 0, `mem_we` in cycle 1, `cpu_ack` in cycle 2. CPU read has the same latency as a video read.
- Reset mid-transaction: IDLE on the next edge; no ack, no `mem_we`.
- `cpu_halt` lags `vid_dma_req` by exactly one cycle.

## Structure
- Shared include `chroni_mem.vh`: state encodings, `ADDR_W` default, and the VRAM size constant; chroni and the CPU bus decoder reuse these.
- Single module with the latency counter inline. No sub-module is warranted.

## Test plan
- Video read of address 0x1E05, memory model returns 0x41, `MEM_LATENCY`=2 -> `vid_rd_ack` exactly in cycle 4 with `vid_data`=0x41, one cycle wide.
- CPU write 0x5A to 0x0010 with `vid_dma_req`=0 -> `mem_we` in cycle 1 with addr 0x0010 and data 0x5A, `cpu_ack` in cycle 2; a later video read of 0x0010 returns 0x5A.
- Same-cycle `vid_rd_req` and `cpu_req` with `vid_dma_req`=0 -> video served first; CPU ack arrives after `vid_rd_ack` plus the CPU latency.
- `vid_dma_req` rises during a CPU read -> CPU read completes with correct data; `cpu_halt`=1 one cycle later; no further CPU acceptance until `vid_dma_req` falls.
- Video request dropped in V_WAIT (frame-start reset) -> no `vid_rd_ack`; the next request is accepted normally.
- Chroni-style back-to-back stream of 80 text reads at 0x1E00–0x1E4F -> 80 acks, each carrying correct data; no duplicate service from a stale `rd_req`.

Source files
------------

// File: rtl/chroni_vram_arbiter_pkg.sv
// Shared constants for the chroni VRAM port: FSM encodings, address width, VRAM size.
package chroni_vram_arbiter_pkg;

  localparam int VRAM_ADDR_W = 13;
  localparam int VRAM_BYTES  = 8192;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_V_ADDR = 3'd1;
  localparam state_t ST_V_WAIT = 3'd2;
  localparam state_t ST_V_ACK  = 3'd3;
  localparam state_t ST_C_ADDR = 3'd4;
  localparam state_t ST_C_WAIT = 3'd5;
  localparam state_t ST_C_ACK  = 3'd6;

endpackage

// File: rtl/chroni_vram_arbiter.sv
// Single synchronous VRAM port shared between chroni video reads and CPU accesses.
// Video wins ties; vid_dma_req blocks new CPU acceptance and drives cpu_halt.
module chroni_vram_arbiter
  import chroni_vram_arbiter_pkg::*;
#(
  parameter int ADDR_W      = VRAM_ADDR_W,
  parameter int MEM_LATENCY = 2
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              vid_rd_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_rd_ack,
  output logic [7:0]        vid_data,
  input  logic              vid_dma_req,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_halt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata
);

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LATENCY - 1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [2:0]        lat_cnt_r;
  logic              lat_done_s;
  logic              cpu_we_r;
  logic              cpu_ack_r;
  logic              cpu_halt_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [7:0]        mem_wdata_r;
  logic [7:0]        vid_data_r;
  logic [7:0]        cpu_rdata_r;

  assign lat_done_s = (lat_cnt_r == 3'd0);

  // Next-state selection; acceptance only happens from IDLE, so an ack cycle never re-accepts.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (vid_rd_req) begin
          state_nxt_s = ST_V_ADDR;
        end else if (cpu_req && !vid_dma_req) begin
          state_nxt_s = ST_C_ADDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_V_ADDR: state_nxt_s = ST_V_WAIT;
      ST_V_WAIT: begin
        if (lat_done_s) begin
          state_nxt_s = ST_V_ACK;
        end else begin
          state_nxt_s = ST_V_WAIT;
        end
      end
      ST_V_ACK:  state_nxt_s = ST_IDLE;
      ST_C_ADDR: begin
        if (cpu_we_r) begin
          state_nxt_s = ST_C_ACK;
        end else begin
          state_nxt_s = ST_C_WAIT;
        end
      end
      ST_C_WAIT: begin
        if (lat_done_s) begin
          state_nxt_s = ST_C_ACK;
        end else begin
          state_nxt_s = ST_C_WAIT;
        end
      end
      ST_C_ACK:  state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // State, latency counter, latched request and captured read data.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      lat_cnt_r   <= 3'd0;
      cpu_we_r    <= 1'b0;
      cpu_ack_r   <= 1'b0;
      cpu_halt_r  <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 8'h00;
      vid_data_r  <= 8'h00;
      cpu_rdata_r <= 8'h00;
    end else begin
      state_r    <= state_nxt_s;
      cpu_halt_r <= vid_dma_req;
      cpu_ack_r  <= (state_nxt_s == ST_C_ACK);
      mem_we_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (vid_rd_req) begin
            mem_addr_r <= vid_addr;
          end else if (cpu_req && !vid_dma_req) begin
            mem_addr_r  <= cpu_addr;
            mem_wdata_r <= cpu_wdata;
            cpu_we_r    <= cpu_we;
            mem_we_r    <= cpu_we;
          end
        end
        ST_V_ADDR, ST_C_ADDR: lat_cnt_r <= LAT_LOAD;
        ST_V_WAIT: begin
          if (lat_done_s) begin
            vid_data_r <= mem_rdata;
          end else begin
            lat_cnt_r <= lat_cnt_r - 3'd1;
          end
        end
        ST_C_WAIT: begin
          if (lat_done_s) begin
            cpu_rdata_r <= mem_rdata;
          end else begin
            lat_cnt_r <= lat_cnt_r - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // The video ack is gated by the live request so a dropped request aborts silently.
  assign vid_rd_ack = (state_r == ST_V_ACK) && vid_rd_req;
  assign vid_data   = vid_data_r;
  assign cpu_rdata  = cpu_rdata_r;
  assign cpu_ack    = cpu_ack_r;
  assign cpu_halt   = cpu_halt_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign mem_we     = mem_we_r;

endmodule
